fp16_accum_seq: RTL and testbench

//  Sequential FP16 vector-sum controller wrapped around the combinational fp16 adder.

---
 rtl/fp16_accum_seq.sv | 142 ++++++++++++++
 tb/tb_fp16_accum_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fp16_accum_seq.sv
// fp16_accum_seq: sequential FP16 vector-sum controller around an external
// combinational FP16 adder. Operands arrive on an in_valid/in_ready handshake
// at one beat per cycle. The running sum is held in acc and fed back to the
// adder. The final sum and a sticky NaN flag are presented on an
// out_valid/out_ready handshake.
// Optional feature macro: FP16_ACC_STATUS_EN. It adds the out_inf sticky
// infinity flag.
module fp16_accum_seq #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] vec_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    output logic [15:0]      add_a,
    output logic [15:0]      add_b,
    input  logic [15:0]      add_out,
    input  logic             add_valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_nan,
`ifdef FP16_ACC_STATUS_EN
    output logic             out_inf,
`endif
    output logic             busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Canonical quiet NaN stored once any operand was NaN.
    localparam logic [15:0] QNAN = 16'h7E00;

    logic [1:0]       state_q, state_d;
    logic [15:0]      acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             nan_q, nan_d;
    logic             beat;

`ifdef FP16_ACC_STATUS_EN
    logic             inf_q, inf_d;
`endif

    assign in_ready  = (state_q == ST_ACCUM);
    assign beat      = in_valid & in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = acc_q;
    assign out_nan   = nan_q;
    assign busy      = (state_q != ST_IDLE);
    assign add_a     = acc_q;
    assign add_b     = in_data;

    // Next-state logic for the FSM, accumulator, beat counter and NaN flag.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        nan_d   = nan_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d = 16'h0000;
                    nan_d = 1'b0;
                    cnt_d = vec_len;
                    // An empty vector completes immediately with a zero sum.
                    state_d = (vec_len == '0) ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (beat) begin
                    if (!nan_q) begin
                        if (add_valid) begin
                            acc_d = add_out;
                        end else begin
                            acc_d = QNAN;
                            nan_d = 1'b1;
                        end
                    end
                    // Once NaN is latched, later operands are consumed but not summed.
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == {{(LEN_W-1){1'b0}}, 1'b1}) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // A start pulse that coincides with the handshake is ignored.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef FP16_ACC_STATUS_EN
    // Sticky infinity flag: set whenever the value stored into acc is +/-Inf.
    always_comb begin
        inf_d = inf_q;
        if (state_q == ST_IDLE && start) begin
            inf_d = 1'b0;
        end else if (state_q == ST_ACCUM && beat
                     && acc_d[14:10] == 5'h1F && acc_d[9:0] == 10'h000) begin
            inf_d = 1'b1;
        end
    end

    // Infinity flag register; cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inf_q <= 1'b0;
        end else begin
            inf_q <= inf_d;
        end
    end

    assign out_inf = inf_q;
`endif

    // State registers. Reset discards any partial sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= 16'h0000;
            cnt_q   <= '0;
            nan_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            nan_q   <= nan_d;
        end
    end

endmodule

// File: tb/tb_fp16_accum_seq.sv
// Directed testbench for fp16_accum_seq. The bench plays the role of the
// external adder: for each beat it drives add_out and add_valid with a
// hand-computed FP16 sum. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_fp16_accum_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  vec_len;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic [15:0] add_out;
    logic        add_valid;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_nan;
    logic        busy;
`ifdef FP16_ACC_STATUS_EN
    logic        out_inf;
`endif

    int checks = 0;
    int errors = 0;

    fp16_accum_seq #(.LEN_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .vec_len   (vec_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_out   (add_out),
        .add_valid (add_valid),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_nan   (out_nan),
`ifdef FP16_ACC_STATUS_EN
        .out_inf   (out_inf),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Pulse start for one cycle, then scramble vec_len to prove it was latched.
    task automatic do_start(input logic [7:0] len);
        start   = 1'b1;
        vec_len = len;
        @(negedge clk);
        start   = 1'b0;
        vec_len = 8'hAA;
        $display("start vec_len=%0d busy=%0b", len, busy);
    endtask

    // One accepted operand. s/v are the adder response for acc_exp + d.
    task automatic beat(input logic [15:0] d, input logic [15:0] s, input logic v,
                        input logic [15:0] acc_exp);
        chk("in_ready_accum", {15'd0, in_ready}, 16'd1);
        chk("add_a", add_a, acc_exp);
        in_valid  = 1'b1;
        in_data   = d;
        add_out   = s;
        add_valid = v;
        #1;
        chk("add_b", add_b, d);
        @(negedge clk);
        $display("beat in=%h add_out=%h add_valid=%0b acc_before=%h", d, s, v, acc_exp);
        in_valid  = 1'b0;
        add_out   = 16'hDEAD;
        add_valid = 1'b1;
    endtask

    // Check a pending result, then complete the output handshake.
    task automatic result(input string tag, input logic [15:0] exp_d, input logic exp_nan);
        chk({tag, "_out_valid"}, {15'd0, out_valid}, 16'd1);
        chk({tag, "_out_data"}, out_data, exp_d);
        chk({tag, "_out_nan"}, {15'd0, out_nan}, {15'd0, exp_nan});
        chk({tag, "_in_ready_done"}, {15'd0, in_ready}, 16'd0);
        $display("result %s out_data=%h out_nan=%0b", tag, out_data, out_nan);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_idle_busy"}, {15'd0, busy}, 16'd0);
        chk({tag, "_idle_out_valid"}, {15'd0, out_valid}, 16'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        vec_len   = 8'd0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        add_out   = 16'h0000;
        add_valid = 1'b1;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {15'd0, in_ready}, 16'd0);
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_out_data", out_data, 16'h0000);
        chk("rst_out_nan", {15'd0, out_nan}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", {15'd0, in_ready}, 16'd0);

        // 1: 1.0 + 2.0 + 3.0 = 6.0, result one cycle after the last beat
        do_start(8'd3);
        chk("t1_busy", {15'd0, busy}, 16'd1);
        beat(16'h3C00, 16'h3C00, 1'b1, 16'h0000);
        chk("t1_no_early_valid", {15'd0, out_valid}, 16'd0);
        beat(16'h4000, 16'h4200, 1'b1, 16'h3C00);
        beat(16'h4200, 16'h4600, 1'b1, 16'h4200);
`ifdef FP16_ACC_STATUS_EN
        chk("t1_out_inf", {15'd0, out_inf}, 16'd0);
`endif
        result("t1", 16'h4600, 1'b0);

        // 2: NaN operand poisons the sum; remaining beats still consumed
        do_start(8'd3);
        beat(16'h3C00, 16'h3C00, 1'b1, 16'h0000);
        beat(16'h7E01, 16'h1234, 1'b0, 16'h3C00);
        chk("t2_still_accum", {15'd0, out_valid}, 16'd0);
        beat(16'h4000, 16'h5555, 1'b1, 16'h7E00);
        result("t2", 16'h7E00, 1'b1);

        // 3: empty vector goes straight to DONE with zero, never ready
        do_start(8'd0);
        chk("t3_in_ready", {15'd0, in_ready}, 16'd0);
        result("t3", 16'h0000, 1'b0);

        // 4: 2.0 + -2.0 = 0; result held while out_ready stays low
        do_start(8'd2);
        beat(16'h4000, 16'h4000, 1'b1, 16'h0000);
        beat(16'hC000, 16'h0000, 1'b1, 16'h4000);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", {15'd0, out_valid}, 16'd1);
            chk("t4_hold_data", out_data, 16'h0000);
            $display("hold cycle %0d out_valid=%0b out_data=%h", i, out_valid, out_data);
            @(negedge clk);
        end
        // start coincident with the handshake must be ignored
        start = 1'b1;
        vec_len = 8'd5;
        result("t4", 16'h0000, 1'b0);
        start = 1'b0;
        @(negedge clk);
        chk("t4_start_ignored", {15'd0, busy}, 16'd0);

        // 5: in_valid gaps; no state change on idle cycles
        do_start(8'd4);
        beat(16'h3C00, 16'h3C00, 1'b1, 16'h0000);
        @(negedge clk);
        chk("t5_gap1_valid", {15'd0, out_valid}, 16'd0);
        beat(16'h3C00, 16'h4000, 1'b1, 16'h3C00);
        @(negedge clk);
        beat(16'h3C00, 16'h4200, 1'b1, 16'h4000);
        @(negedge clk);
        chk("t5_gap3_valid", {15'd0, out_valid}, 16'd0);
        chk("t5_gap3_ready", {15'd0, in_ready}, 16'd1);
        beat(16'h3C00, 16'h4400, 1'b1, 16'h4200);
        result("t5", 16'h4400, 1'b0);

        // 6: asynchronous reset mid-vector, then a fresh one-beat vector
        do_start(8'd4);
        beat(16'h4000, 16'h4000, 1'b1, 16'h0000);
        beat(16'h4000, 16'h4400, 1'b1, 16'h4000);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", {15'd0, busy}, 16'd0);
        chk("t6_rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("t6_rst_in_ready", {15'd0, in_ready}, 16'd0);
        $display("reset mid-vector busy=%0b out_valid=%0b", busy, out_valid);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start(8'd1);
        beat(16'h4000, 16'h4000, 1'b1, 16'h0000);
        result("t6", 16'h4000, 1'b0);

`ifdef FP16_ACC_STATUS_EN
        // 7: overflow to +Inf sets the infinity flag
        do_start(8'd2);
        beat(16'h7BFF, 16'h7BFF, 1'b1, 16'h0000);
        chk("t7_inf_not_yet", {15'd0, out_inf}, 16'd0);
        beat(16'h7BFF, 16'h7C00, 1'b1, 16'h7BFF);
        chk("t7_out_inf", {15'd0, out_inf}, 16'd1);
        result("t7", 16'h7C00, 1'b0);
        do_start(8'd0);
        chk("t7_inf_cleared", {15'd0, out_inf}, 16'd0);
        result("t7b", 16'h0000, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
